// File: rtl/lc_mem_bridge_pkg.sv
// Shared widths, depth and FSM encodings for the layer-controller memory bridge.
package lc_mem_bridge_pkg;

    localparam int LC_MEM_DATA_WIDTH = 32;
    localparam int LC_MEM_ADDR_WIDTH = 16;      // byte address; word address drops 2 LSBs
    localparam int LC_MEM_DEPTH      = 16384;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESP   = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    // Port identifiers used for grant and last_grant
    localparam logic PORT_LC  = 1'b0;
    localparam logic PORT_LOC = 1'b1;

endpackage

// File: rtl/lc_mem_bridge_arb.sv
// Two-requester round-robin arbiter with eligibility mask.
// grant/grant_valid are combinational; last_grant advances only when the
// owner accepts a grant (take).
module lc_mem_arb
    import lc_mem_bridge_pkg::*;
(
    input  logic       CLK,
    input  logic       RESETn,
    input  logic [1:0] req,
    input  logic [1:0] eligible,
    input  logic       take,
    output logic       grant,
    output logic       grant_valid
);

    logic       last_grant;
    logic [1:0] cand;

    assign cand        = req & eligible;
    assign grant_valid = |cand;

    // Pick the single candidate, or the one not served last on a tie
    always_comb begin
        grant = PORT_LC;
        if (cand == 2'b11) begin
            grant = ~last_grant;
        end else if (cand[1]) begin
            grant = PORT_LOC;
        end
    end

    // Remember the winner; reset to LOC so LC wins the first tie
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            last_grant <= PORT_LOC;
        end else if (take && grant_valid) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/lc_mem_bridge.sv
// Memory-side slave for the layer controller 4-phase port plus a local
// master port, sharing one single-port synchronous SRAM.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | sample requests, grant, latch fields into SRAM_A/SRAM_D
// ACCESS | SRAM_CEN low for exactly one cycle
// WAIT   | count down read latency, capture SRAM_Q into granted RDATA
// RESP   | raise granted port's ACK
// HOLD   | keep ACK until that port's REQ falls (4-phase return)
module lc_mem_bridge
    import lc_mem_bridge_pkg::*;
#(
    parameter int DATA_WIDTH = LC_MEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = LC_MEM_ADDR_WIDTH - 2,
    parameter int DEPTH      = LC_MEM_DEPTH,
    parameter int RD_LATENCY = 1                  // valid range 1..3
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic                  LC_REQ,
    input  logic                  LC_WRITE,
    input  logic [ADDR_WIDTH-1:0] LC_ADDR,
    input  logic [DATA_WIDTH-1:0] LC_WDATA,
    output logic [DATA_WIDTH-1:0] LC_RDATA,
    output logic                  LC_ACK,
    input  logic                  LOC_REQ,
    input  logic                  LOC_WRITE,
    input  logic [ADDR_WIDTH-1:0] LOC_ADDR,
    input  logic [DATA_WIDTH-1:0] LOC_WDATA,
    output logic [DATA_WIDTH-1:0] LOC_RDATA,
    output logic                  LOC_ACK,
    output logic                  SRAM_CEN,
    output logic                  SRAM_WEN,
    output logic [ADDR_WIDTH-1:0] SRAM_A,
    output logic [DATA_WIDTH-1:0] SRAM_D,
    input  logic [DATA_WIDTH-1:0] SRAM_Q
);

    // One extra bit so DEPTH == 2**ADDR_WIDTH is representable
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state;
    logic                  sel;         // port currently being served
    logic                  lat_wr;
    logic [1:0]            lat_cnt;

    logic                  grant;
    logic                  grant_valid;
    logic                  g_write;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic [DATA_WIDTH-1:0] g_wdata;
    logic                  g_in_range;
    logic                  sel_req;

    lc_mem_arb u_arb (
        .CLK         (CLK),
        .RESETn      (RESETn),
        .req         ({LOC_REQ, LC_REQ}),
        .eligible    (~{LOC_ACK, LC_ACK}),
        .take        (state == ST_IDLE),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign g_write    = (grant == PORT_LOC) ? LOC_WRITE : LC_WRITE;
    assign g_addr     = (grant == PORT_LOC) ? LOC_ADDR  : LC_ADDR;
    assign g_wdata    = (grant == PORT_LOC) ? LOC_WDATA : LC_WDATA;
    assign g_in_range = ({1'b0, g_addr} < DEPTH_W);
    assign sel_req    = (sel == PORT_LOC) ? LOC_REQ : LC_REQ;

    // Bridge sequencer; all outputs registered here
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state     <= ST_IDLE;
            sel       <= PORT_LC;
            lat_wr    <= 1'b0;
            lat_cnt   <= 2'd0;
            LC_ACK    <= 1'b0;
            LOC_ACK   <= 1'b0;
            LC_RDATA  <= '0;
            LOC_RDATA <= '0;
            SRAM_CEN  <= 1'b1;
            SRAM_WEN  <= 1'b1;
            SRAM_A    <= '0;
            SRAM_D    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        sel    <= grant;
                        lat_wr <= g_write;
                        if (g_in_range) begin
                            // SRAM_A/SRAM_D double as the latched request fields
                            SRAM_CEN <= 1'b0;
                            SRAM_WEN <= ~g_write;
                            SRAM_A   <= g_addr;
                            SRAM_D   <= g_wdata;
                            state    <= ST_ACCESS;
                        end else begin
                            // Out of range: SRAM untouched, reads return zero
                            if (!g_write) begin
                                if (grant == PORT_LOC) LOC_RDATA <= '0;
                                else                   LC_RDATA  <= '0;
                            end
                            state <= ST_RESP;
                        end
                    end
                end
                ST_ACCESS: begin
                    SRAM_CEN <= 1'b1;
                    SRAM_WEN <= 1'b1;
                    if (lat_wr) begin
                        state <= ST_RESP;
                    end else begin
                        lat_cnt <= 2'(RD_LATENCY - 1);
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        if (sel == PORT_LOC) LOC_RDATA <= SRAM_Q;
                        else                 LC_RDATA  <= SRAM_Q;
                        state <= ST_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                ST_RESP: begin
                    if (sel == PORT_LOC) LOC_ACK <= 1'b1;
                    else                 LC_ACK  <= 1'b1;
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!sel_req) begin
                        LC_ACK  <= 1'b0;
                        LOC_ACK <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lc_mem_bridge.sv
// Bench for lc_mem_bridge: instance A (RD_LATENCY=1) and B (RD_LATENCY=3),
// both with a 15-bit word address so DEPTH=16384 leaves an out-of-range half.
// Port ids: 0=A.LC 1=A.LOC 2=B.LC 3=B.LOC
`timescale 1ns/1ps
module tb_lc_mem_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_a_n, rst_b_n;
    logic [3:0]         req_v, wr_v;
    logic [3:0][14:0]   addr_v;
    logic [3:0][31:0]   wd_v;
    wire  [3:0][31:0]   rd_v;
    wire  [3:0]         ack_v;
    wire  [1:0]         cen_v, wen_v;
    wire  [1:0][14:0]   a_v;
    wire  [1:0][31:0]   d_v;
    wire  [1:0][31:0]   q_v;

    int total = 0;
    int bad   = 0;

    lc_mem_bridge #(.ADDR_WIDTH(15), .DEPTH(16384), .RD_LATENCY(1)) u_dut_a (
        .CLK(clk), .RESETn(rst_a_n),
        .LC_REQ(req_v[0]), .LC_WRITE(wr_v[0]), .LC_ADDR(addr_v[0]), .LC_WDATA(wd_v[0]),
        .LC_RDATA(rd_v[0]), .LC_ACK(ack_v[0]),
        .LOC_REQ(req_v[1]), .LOC_WRITE(wr_v[1]), .LOC_ADDR(addr_v[1]), .LOC_WDATA(wd_v[1]),
        .LOC_RDATA(rd_v[1]), .LOC_ACK(ack_v[1]),
        .SRAM_CEN(cen_v[0]), .SRAM_WEN(wen_v[0]), .SRAM_A(a_v[0]), .SRAM_D(d_v[0]), .SRAM_Q(q_v[0])
    );

    lc_mem_bridge #(.ADDR_WIDTH(15), .DEPTH(16384), .RD_LATENCY(3)) u_dut_b (
        .CLK(clk), .RESETn(rst_b_n),
        .LC_REQ(req_v[2]), .LC_WRITE(wr_v[2]), .LC_ADDR(addr_v[2]), .LC_WDATA(wd_v[2]),
        .LC_RDATA(rd_v[2]), .LC_ACK(ack_v[2]),
        .LOC_REQ(req_v[3]), .LOC_WRITE(wr_v[3]), .LOC_ADDR(addr_v[3]), .LOC_WDATA(wd_v[3]),
        .LOC_RDATA(rd_v[3]), .LOC_ACK(ack_v[3]),
        .SRAM_CEN(cen_v[1]), .SRAM_WEN(wen_v[1]), .SRAM_A(a_v[1]), .SRAM_D(d_v[1]), .SRAM_Q(q_v[1])
    );

    // SRAM models: Q outside a read slot is junk so mistimed capture shows up
    bit   [31:0] sram_mem [2][32768];
    logic [31:0] qp [2][3];
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!cen_v[k] && !wen_v[k]) sram_mem[k][a_v[k]] <= d_v[k];
            qp[k][0] <= (!cen_v[k] && wen_v[k]) ? sram_mem[k][a_v[k]] : 32'hBAD0_0BAD;
            qp[k][1] <= qp[k][0];
            qp[k][2] <= qp[k][1];
        end
    end
    assign q_v[0] = qp[0][0];
    assign q_v[1] = qp[1][2];

    // Reference model and scoreboard
    bit   [31:0] ref_mem [2][32768];
    logic [31:0] last_rd [4];
    logic [31:0] exp_q [4][$];
    int          ack_order[$];
    int          cen_cnt [2];
    logic [1:0]       last_wen;
    logic [1:0][14:0] last_a;
    logic [3:0]  ack_prev = 4'b0;
    logic [31:0] mon_exp;

    // Monitor: count SRAM cycles, pop expectations on each ACK rise
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!cen_v[k]) begin
                cen_cnt[k]++;
                last_wen[k] = wen_v[k];
                last_a[k]   = a_v[k];
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (ack_v[i] && !ack_prev[i]) begin
                if (i < 2) ack_order.push_back(i);
                total++;
                assert (exp_q[i].size() != 0) else begin
                    bad++; $error("FAIL spurious_ack id=%0d got=ack expected=no_ack", i);
                end
                if (exp_q[i].size() != 0) begin
                    mon_exp = exp_q[i].pop_front();
                    total++;
                    assert (rd_v[i] === mon_exp) else begin
                        bad++; $error("FAIL rdata id=%0d got=%h expected=%h", i, rd_v[i], mon_exp);
                    end
                end
            end
        end
        ack_prev = ack_v;
    end

    // One full 4-phase transaction; exp_lat/exp_cen < 0 skip that check
    task automatic txn(input int id, input bit wr, input logic [14:0] addr, input logic [31:0] wd,
                       input int hold_extra, input int exp_lat, input int exp_cen);
        int inst = id / 2;
        int n  = 0;
        int hi = 0;
        int c0;
        bit oor;
        logic [31:0] e;
        oor = (addr >= 15'h4000);
        if (wr) begin
            e = last_rd[id];
            if (!oor) ref_mem[inst][addr] = wd;
        end else begin
            e = oor ? 32'h0 : ref_mem[inst][addr];
            last_rd[id] = e;
        end
        exp_q[id].push_back(e);
        c0 = cen_cnt[inst];
        wr_v[id] = wr; addr_v[id] = addr; wd_v[id] = wd; req_v[id] = 1'b1;
        while (ack_v[id] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
            // Fields are latched on the grant edge; later changes must be ignored
            if (n == 1 && exp_lat >= 0) begin
                wr_v[id] = ~wr; addr_v[id] = ~addr; wd_v[id] = ~wd;
            end
        end
        total++;
        if (exp_lat >= 0) begin
            assert (n == exp_lat) else begin
                bad++; $error("FAIL latency id=%0d got=%0d expected=%0d", id, n, exp_lat);
            end
        end else begin
            assert (n < 40) else begin
                bad++; $error("FAIL ack_timeout id=%0d got=%0d expected=<40", id, n);
            end
        end
        for (int k = 0; k < hold_extra; k++) begin
            @(negedge clk);
            if (ack_v[id] === 1'b1) hi++;
        end
        if (hold_extra > 0) begin
            total++;
            assert (hi == hold_extra) else begin
                bad++; $error("FAIL ack_hold id=%0d got=%0d expected=%0d", id, hi, hold_extra);
            end
        end
        req_v[id] = 1'b0;
        @(negedge clk);
        total++;
        assert (ack_v[id] === 1'b0) else begin
            bad++; $error("FAIL ack_fall id=%0d got=%b expected=0", id, ack_v[id]);
        end
        if (exp_cen >= 0) begin
            total++;
            assert (cen_cnt[inst] - c0 == exp_cen) else begin
                bad++; $error("FAIL cen_count id=%0d got=%0d expected=%0d", id, cen_cnt[inst] - c0, exp_cen);
            end
        end
        if (exp_cen == 1) begin
            total++;
            assert ({last_wen[inst], last_a[inst]} === {~wr, addr}) else begin
                bad++; $error("FAIL sram_cmd id=%0d got=%b/%h expected=%b/%h",
                              id, last_wen[inst], last_a[inst], ~wr, addr);
            end
        end
    endtask

    int n;
    int c0;

    initial begin
        req_v = '0; wr_v = '0; addr_v = '0; wd_v = '0;
        for (int i = 0; i < 4; i++) last_rd[i] = 32'h0;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        repeat (3) @(negedge clk);

        total++;
        assert ({ack_v[1:0], rd_v[0], rd_v[1], cen_v[0], wen_v[0], a_v[0], d_v[0]}
                === {2'b00, 64'h0, 1'b1, 1'b1, 15'h0, 32'h0}) else begin
            bad++; $error("FAIL reset_a got=%b %h %h %b %b %h %h expected=00 0 0 1 1 0 0",
                          ack_v[1:0], rd_v[0], rd_v[1], cen_v[0], wen_v[0], a_v[0], d_v[0]);
        end
        total++;
        assert ({ack_v[3:2], rd_v[2], rd_v[3], cen_v[1], wen_v[1], a_v[1], d_v[1]}
                === {2'b00, 64'h0, 1'b1, 1'b1, 15'h0, 32'h0}) else begin
            bad++; $error("FAIL reset_b got=%b %h %h %b %b %h %h expected=00 0 0 1 1 0 0",
                          ack_v[3:2], rd_v[2], rd_v[3], cen_v[1], wen_v[1], a_v[1], d_v[1]);
        end
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        @(negedge clk);

        // Instance A basic traffic, back-to-back
        txn(0, 1'b1, 15'h0010, 32'hDEADBEEF, 0, 3, 1);
        txn(0, 1'b0, 15'h0010, 32'h0,        0, 4, 1);
        txn(1, 1'b1, 15'h0001, 32'hCAFEF00D, 0, 3, 1);
        txn(0, 1'b0, 15'h0001, 32'h0,        5, 4, 1);
        txn(1, 1'b0, 15'h0010, 32'h0,        2, 4, 1);

        // REQ dropped before ACK: access completes, ACK pulses one cycle
        ref_mem[0][15'h0030] = 32'h0BADF00D;
        exp_q[0].push_back(last_rd[0]);
        wr_v[0] = 1'b1; addr_v[0] = 15'h0030; wd_v[0] = 32'h0BADF00D; req_v[0] = 1'b1;
        @(negedge clk);
        req_v[0] = 1'b0;
        n = 0;
        while (ack_v[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        total++;
        assert (n < 20 && ack_v[0] === 1'b0) else begin
            bad++; $error("FAIL ack_pulse got=wait%0d/ack%b expected=<20/0", n, ack_v[0]);
        end
        txn(0, 1'b0, 15'h0030, 32'h0, 0, 4, 1);

        // Fresh reset on A so LC wins the first tie
        rst_a_n = 1'b0;
        @(negedge clk);
        rst_a_n = 1'b1;
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        @(negedge clk);
        ack_order.delete();
        c0 = cen_cnt[0];
        fork
            txn(0, 1'b0, 15'h0001, 32'h0,        0, -1, -1);
            txn(1, 1'b1, 15'h0002, 32'h12345678, 0, -1, -1);
        join
        total++;
        assert (ack_order.size() == 2 && ack_order[0] == 0 && ack_order[1] == 1) else begin
            bad++; $error("FAIL tie_order1 got=n%0d first=%0d expected=n2 first=0",
                          ack_order.size(), ack_order[0]);
        end
        total++;
        assert (cen_cnt[0] - c0 == 2) else begin
            bad++; $error("FAIL tie_cen got=%0d expected=2", cen_cnt[0] - c0);
        end
        // LC served alone last, so LOC wins the next tie
        txn(0, 1'b0, 15'h0002, 32'h0, 0, 4, 1);
        ack_order.delete();
        fork
            txn(0, 1'b1, 15'h0003, 32'h0F0F0F0F, 0, -1, -1);
            txn(1, 1'b0, 15'h0001, 32'h0,        0, -1, -1);
        join
        total++;
        assert (ack_order.size() == 2 && ack_order[0] == 1 && ack_order[1] == 0) else begin
            bad++; $error("FAIL tie_order2 got=n%0d first=%0d expected=n2 first=1",
                          ack_order.size(), ack_order[0]);
        end
        txn(1, 1'b0, 15'h0003, 32'h0, 0, 4, 1);

        // Instance B: RD_LATENCY=3
        txn(3, 1'b1, 15'h0020, 32'hA5A5A5A5, 0, 3, 1);
        txn(2, 1'b0, 15'h0020, 32'h0,        0, 6, 1);

        // Reset while B is in WAIT
        wr_v[2] = 1'b0; addr_v[2] = 15'h0020; req_v[2] = 1'b1;
        repeat (3) @(negedge clk);
        rst_b_n = 1'b0;
        #1;
        total++;
        assert ({cen_v[1], ack_v[3:2], rd_v[2]} === {1'b1, 2'b00, 32'h0}) else begin
            bad++; $error("FAIL reset_mid got=%b %b %h expected=1 00 0", cen_v[1], ack_v[3:2], rd_v[2]);
        end
        req_v[2] = 1'b0;
        exp_q[2].delete(); exp_q[3].delete();
        last_rd[2] = 32'h0; last_rd[3] = 32'h0;
        @(negedge clk);
        rst_b_n = 1'b1;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (ack_v[3:2] !== 2'b00 || cen_v[1] !== 1'b1) n++;
        end
        total++;
        assert (n == 0) else begin
            bad++; $error("FAIL quiet_after_reset got=%0d expected=0", n);
        end

        // Out-of-range traffic on B
        txn(2, 1'b0, 15'h0020, 32'h0,        0, 6, 1);
        txn(2, 1'b1, 15'h4000, 32'h11112222, 0, -1, 0);
        txn(2, 1'b0, 15'h4000, 32'h0,        0, -1, 0);
        txn(3, 1'b0, 15'h0020, 32'h0,        1, 6, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
